// File: rtl/numlock_supervisor.sv
// numlock_supervisor: attempt supervisor sitting between the debounced U/Z
// buttons and the number-lock state machine. Forwards button levels, counts
// consecutive bad attempts, imposes a timed lockout, aborts stalled attempts
// with a one-cycle lock reset pulse and masks buttons while the lock opens.
// Optional feature macro: NUMLOCK_SUP_STATS_EN (enables the open_cnt counter;
// when undefined open_cnt is tied to zero).
module numlock_supervisor #(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 64,
    parameter int unsigned IDLE_CYCLES    = 32,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             U_in,
    input  logic             Z_in,
    input  logic             q_I,
    input  logic             q_Bad,
    input  logic             q_Opening,
    output logic             U,
    output logic             Z,
    output logic             sm_reset,
    output logic             locked_out,
    output logic [3:0]       fail_cnt,
    output logic [CNT_W-1:0] open_cnt
);

    localparam int unsigned IW = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned LW = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAILS);

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_ATTEMPT = 5'b00010,
        S_BAD     = 5'b00100,
        S_LOCKOUT = 5'b01000,
        S_OPEN    = 5'b10000
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]    fail_cnt_q, fail_cnt_d;
    logic          u_q, u_d;
    logic          z_q, z_d;
    logic          sm_reset_q, sm_reset_d;
    logic          pass_en;
    logic          any_btn;
    logic [3:0]    fail_inc;

    assign any_btn  = U_in | Z_in;
    assign fail_inc = fail_cnt_q + 4'd1;

    // State and datapath registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idle_cnt_q <= '0;
            lock_cnt_q <= '0;
            fail_cnt_q <= '0;
            u_q        <= 1'b0;
            z_q        <= 1'b0;
            sm_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            u_q        <= u_d;
            z_q        <= z_d;
            sm_reset_q <= sm_reset_d;
        end
    end

    // Next-state, attempt counters and abort pulse; illegal encodings fall to IDLE.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        lock_cnt_d = lock_cnt_q;
        fail_cnt_d = fail_cnt_q;
        sm_reset_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_btn) begin
                    state_d    = S_ATTEMPT;
                    idle_cnt_d = '0;
                end
            end
            S_ATTEMPT: begin
                if (q_Opening) begin
                    state_d    = S_OPEN;
                    fail_cnt_d = '0;
                end else if (q_Bad) begin
                    fail_cnt_d = fail_inc;
                    if (fail_inc == FAIL_LIMIT) begin
                        state_d    = S_LOCKOUT;
                        lock_cnt_d = LOCK_LOAD;
                    end else begin
                        state_d = S_BAD;
                    end
                end else if (q_I && !any_btn) begin
                    state_d    = S_IDLE;
                    idle_cnt_d = '0;
                end else if (!any_btn) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        sm_reset_d = 1'b1;
                        idle_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            S_BAD: begin
                if (q_I) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                // A held button keeps the counter parked at zero until release.
                if (lock_cnt_q == '0) begin
                    if (!any_btn) begin
                        state_d    = S_IDLE;
                        fail_cnt_d = '0;
                    end
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
            end
            S_OPEN: begin
                if (q_I) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: button pass-through gating and lockout flag.
    always_comb begin
        pass_en    = (state_q == S_IDLE) || (state_q == S_ATTEMPT) || (state_q == S_BAD);
        u_d        = pass_en & U_in;
        z_d        = pass_en & Z_in;
        locked_out = (state_q == S_LOCKOUT);
    end

    assign U        = u_q;
    assign Z        = z_q;
    assign sm_reset = sm_reset_q;
    assign fail_cnt = fail_cnt_q;

`ifdef NUMLOCK_SUP_STATS_EN
    logic [CNT_W-1:0] open_cnt_q, open_cnt_d;

    // Saturating count of successful opens.
    always_comb begin
        open_cnt_d = open_cnt_q;
        if ((state_q == S_ATTEMPT) && q_Opening && (open_cnt_q != '1)) begin
            open_cnt_d = open_cnt_q + 1'b1;
        end
    end

    // Open counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            open_cnt_q <= '0;
        end else begin
            open_cnt_q <= open_cnt_d;
        end
    end

    assign open_cnt = open_cnt_q;
`else
    assign open_cnt = '0;
`endif

endmodule

// File: tb/tb_numlock_supervisor.sv
// Testbench for numlock_supervisor: fixed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_numlock_supervisor;

    localparam int MAXF  = 3;
    localparam int LOCKC = 64;
    localparam int IDLEC = 32;
    localparam int CW    = 8;
`ifdef NUMLOCK_SUP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int M_IDLE = 0, M_ATT = 1, M_BAD = 2, M_LOCK = 3, M_OPEN = 4;

    logic          clk = 1'b0;
    logic          reset, U_in, Z_in, q_I, q_Bad, q_Opening;
    logic          U, Z, sm_reset, locked_out;
    logic [3:0]    fail_cnt;
    logic [CW-1:0] open_cnt;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    int mode, idle_run, lock_elapsed, m_fail, m_open;
    bit m_U, m_Z, m_sr, m_lo;

    numlock_supervisor #(
        .MAX_FAILS     (MAXF),
        .LOCKOUT_CYCLES(LOCKC),
        .IDLE_CYCLES   (IDLEC),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .U_in      (U_in),
        .Z_in      (Z_in),
        .q_I       (q_I),
        .q_Bad     (q_Bad),
        .q_Opening (q_Opening),
        .U         (U),
        .Z         (Z),
        .sm_reset  (sm_reset),
        .locked_out(locked_out),
        .fail_cnt  (fail_cnt),
        .open_cnt  (open_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, written from the supervisor's rules.
    task automatic model_edge(input bit u, z, qi, qb, qo, rst);
        bit btn;
        bit pass;
        btn = u | z;
        if (rst) begin
            mode = M_IDLE; idle_run = 0; lock_elapsed = 0;
            m_fail = 0; m_open = 0; m_U = 0; m_Z = 0; m_sr = 0;
        end else begin
            pass = (mode == M_IDLE) || (mode == M_ATT) || (mode == M_BAD);
            m_U  = pass && u;
            m_Z  = pass && z;
            m_sr = 0;
            case (mode)
                M_IDLE: if (btn) begin mode = M_ATT; idle_run = 0; end
                M_ATT: begin
                    if (qo) begin
                        mode = M_OPEN; m_fail = 0;
                        if (STATS && m_open < (1 << CW) - 1) m_open++;
                    end else if (qb) begin
                        m_fail++;
                        if (m_fail == MAXF) begin mode = M_LOCK; lock_elapsed = 0; end
                        else mode = M_BAD;
                    end else if (qi && !btn) begin
                        mode = M_IDLE;
                    end else if (!btn) begin
                        idle_run++;
                        if (idle_run == IDLEC) begin
                            m_sr = 1; mode = M_IDLE; idle_run = 0;
                        end
                    end else begin
                        idle_run = 0;
                    end
                end
                M_BAD:  if (qi) mode = M_IDLE;
                M_OPEN: if (qi) mode = M_IDLE;
                M_LOCK: begin
                    lock_elapsed++;
                    if (lock_elapsed >= LOCKC && !btn) begin
                        mode = M_IDLE; m_fail = 0;
                    end
                end
                default: mode = M_IDLE;
            endcase
        end
        m_lo = (mode == M_LOCK);
    endtask

    // Drive one cycle, advance the model, compare every output.
    task automatic step(input bit u, z, qi, qb, qo, rst);
        U_in = u; Z_in = z; q_I = qi; q_Bad = qb; q_Opening = qo; reset = rst;
        @(posedge clk);
        model_edge(u, z, qi, qb, qo, rst);
        #1;
        check("U", int'(U), int'(m_U));
        check("Z", int'(Z), int'(m_Z));
        check("sm_reset", int'(sm_reset), int'(m_sr));
        check("locked_out", int'(locked_out), int'(m_lo));
        check("fail_cnt", int'(fail_cnt), m_fail);
        check("open_cnt", int'(open_cnt), m_open);
    endtask

    // One failed attempt from IDLE; returns the lock to I unless locked out.
    task automatic bad_attempt(input bit hold_u);
        step(1, 0, 0, 0, 0, 0);
        step(hold_u, 0, 0, 1, 0, 0);
        if (!locked_out) step(0, 0, 1, 0, 0, 0);
    endtask

    typedef struct {
        bit u, z, qi, qb, qo, rst;
        bit eu, ez, esr, elo;
        int ef;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int n, pulses, pulse_at;

        tbl[0]  = '{0,0,0,0,0,1, 0,0,0,0, 0};
        tbl[1]  = '{1,0,0,0,0,0, 1,0,0,0, 0};
        tbl[2]  = '{0,1,0,0,0,0, 0,1,0,0, 0};
        tbl[3]  = '{0,0,0,1,0,0, 0,0,0,0, 1};
        tbl[4]  = '{1,0,0,0,0,0, 1,0,0,0, 1};
        tbl[5]  = '{0,0,1,0,0,0, 0,0,0,0, 1};
        tbl[6]  = '{0,1,0,0,0,0, 0,1,0,0, 1};
        tbl[7]  = '{0,0,0,1,0,0, 0,0,0,0, 2};
        tbl[8]  = '{0,0,1,0,0,0, 0,0,0,0, 2};
        tbl[9]  = '{1,0,0,0,0,0, 1,0,0,0, 2};
        tbl[10] = '{1,0,0,1,0,0, 1,0,0,1, 3};
        tbl[11] = '{1,0,0,0,0,0, 0,0,0,1, 3};
        tbl[12] = '{1,0,0,0,0,1, 0,0,0,0, 0};
        tbl[13] = '{0,0,0,0,1,0, 0,0,0,0, 0};
        tbl[14] = '{0,1,0,0,0,0, 0,1,0,0, 0};
        tbl[15] = '{0,0,0,1,1,0, 0,0,0,0, 0};
        tbl[16] = '{1,0,0,0,0,0, 0,0,0,0, 0};
        tbl[17] = '{0,0,1,0,0,0, 0,0,0,0, 0};
        tbl[18] = '{1,0,0,0,0,0, 1,0,0,0, 0};
        tbl[19] = '{0,0,1,0,0,0, 0,0,0,0, 0};
        tbl[20] = '{0,0,0,0,0,0, 0,0,0,0, 0};

        reset = 1; U_in = 0; Z_in = 0; q_I = 0; q_Bad = 0; q_Opening = 0;
        mode = M_IDLE; idle_run = 0; lock_elapsed = 0; m_fail = 0; m_open = 0;
        m_U = 0; m_Z = 0; m_sr = 0; m_lo = 0;

        // fixed vector table
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].u, tbl[i].z, tbl[i].qi, tbl[i].qb, tbl[i].qo, tbl[i].rst);
            check($sformatf("tbl%0d_U", i), int'(U), int'(tbl[i].eu));
            check($sformatf("tbl%0d_Z", i), int'(Z), int'(tbl[i].ez));
            check($sformatf("tbl%0d_smr", i), int'(sm_reset), int'(tbl[i].esr));
            check($sformatf("tbl%0d_lo", i), int'(locked_out), int'(tbl[i].elo));
            check($sformatf("tbl%0d_fail", i), int'(fail_cnt), tbl[i].ef);
        end
        check("open_after_table", int'(open_cnt), STATS ? 1 : 0);

        // stalled attempt: one press then silence
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        pulses = 0; pulse_at = 0;
        for (int i = 1; i <= 45; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (sm_reset) begin
                pulses++;
                if (pulse_at == 0) pulse_at = i;
            end
        end
        check("idle_pulse_cycle", pulse_at, IDLEC);
        check("idle_pulse_count", pulses, 1);

        // three bad attempts, lockout with buttons released
        step(0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= MAXF; k++) begin
            bad_attempt(0);
            check("fail_seq", int'(fail_cnt), k);
        end
        check("lockout_entered", int'(locked_out), 1);
        n = 1;
        while (locked_out && n < 300) begin
            step(0, 0, 1, 0, 0, 0);
            if (locked_out) n++;
        end
        check("lockout_len", n, LOCKC);
        check("fail_after_lockout", int'(fail_cnt), 0);

        // button held through lockout expiry
        for (int k = 1; k <= MAXF; k++) bad_attempt(1);
        for (int i = 0; i < LOCKC + 20; i++) step(1, 0, 0, 0, 0, 0);
        check("held_lockout", int'(locked_out), 1);
        step(0, 0, 0, 0, 0, 0);
        check("held_release", int'(locked_out), 0);

        // two bad attempts then correct code
        for (int k = 1; k <= MAXF - 1; k++) bad_attempt(0);
        check("two_bad", int'(fail_cnt), MAXF - 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("open_clears_fail", int'(fail_cnt), 0);
        check("open_no_lockout", int'(locked_out), 0);
        step(1, 1, 0, 0, 0, 0);
        check("open_mask", int'(U | Z), 0);
        step(0, 0, 1, 0, 0, 0);

        // reset mid-lockout
        for (int k = 1; k <= MAXF; k++) bad_attempt(0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        check("rst_lo", int'(locked_out), 0);
        check("rst_fail", int'(fail_cnt), 0);
        check("rst_open", int'(open_cnt), 0);

        // randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            int bp;
            bp = (i / 500) % 2 == 0 ? 3 : 12;
            step($urandom_range(0, bp - 1) == 0, $urandom_range(0, bp - 1) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/numlock_supervisor.md
# numlock_supervisor

Attempt supervisor between the debounced U/Z buttons and the 11-state number-lock state machine. Passes button levels to the lock, counts consecutive bad attempts from the lock's `q_Bad` flag, and imposes a timed lockout after `MAX_FAILS` failures. Aborts stalled attempts by pulsing a lock reset, and masks buttons while the lock is opening.

## Interface
- `MAX_FAILS`, 3: consecutive bad attempts that trigger lockout (1..15).
- `LOCKOUT_CYCLES`, 64: lockout duration in clk cycles (≥2).
- `IDLE_CYCLES`, 32: consecutive no-button cycles that abort an attempt (≥2).
- `CNT_W`, 8: width of `open_cnt`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `U_in`, `Z_in`  in  1 each  debounced button levels.
- `q_I`, `q_Bad`, `q_Opening`  in  1 each  state flags from the lock.
- `U`, `Z`  out  1 each  registered, gated button levels to the lock.
- `sm_reset`  out  1  one-cycle pulse; ORed into the lock's reset at top level.
- `locked_out`  out  1  high during LOCKOUT.
- `fail_cnt`  out  4  consecutive bad attempts.
- `open_cnt`  out  CNT_W  successful opens, saturating.

## Operation
- States: IDLE, ATTEMPT, BAD, LOCKOUT, OPEN. One-hot encoding; any illegal encoding goes to IDLE.
- Pass-through is enabled in IDLE, ATTEMPT and BAD. When enabled, `U <= U_in`, `Z <= Z_in`; otherwise `U <= 0`, `Z <= 0`.
- IDLE:
  - If `U_in | Z_in`, go to ATTEMPT and clear idle_cnt.
- ATTEMPT (priority order):
  - `q_Opening` → go to OPEN; set `fail_cnt <= 0`; increment `open_cnt` (saturate at all-ones).
  - `q_Bad` → set `fail_cnt <= fail_cnt+1`. Go to LOCKOUT if `fail_cnt+1 == MAX_FAILS`, else go to BAD.
  - `q_I & !U_in & !Z_in` → go to IDLE.
  - `!U_in & !Z_in` → idle_cnt++. When idle_cnt reaches `IDLE_CYCLES-1`: pulse `sm_reset`, clear idle_cnt, go to IDLE.
  - Any button high → clear idle_cnt.
- BAD:
  - Wait for `q_I`, then go to IDLE. The user releases both buttons to clear the lock.
- LOCKOUT:
  - On entry, load lock_cnt with `LOCKOUT_CYCLES-1`, then decrement each cycle.
  - Forced U=Z=0 drives the lock out of Bad to I.
  - When lock_cnt==0 and `!U_in & !Z_in`: go to IDLE and set `fail_cnt <= 0`. A held button extends lockout until release.
- OPEN:
  - Buttons are masked. When `q_I` (the lock's own timeout), go to IDLE.
- `fail_cnt` is kept across IDLE. It clears only on open, lockout exit, or reset.
- `sm_reset` is asserted only from ATTEMPT and never in two consecutive cycles.

## Timing
- Reset values: state IDLE; `U`, `Z`, `sm_reset`, `locked_out` = 0; `fail_cnt` = 0; `open_cnt` = 0; idle_cnt and lock_cnt = 0.
- `U`/`Z` lag `U_in`/`Z_in` by 1 cycle. The lock flag reaches the supervisor 1 cycle after the lock registers it.
- `locked_out` is asserted the cycle after `q_Bad` is sampled with the final failure. Minimum lockout is `LOCKOUT_CYCLES` cycles.
- `sm_reset` is high for exactly 1 cycle, registered. State is IDLE in the same cycle.
- Reset in any state returns to IDLE next edge. Reset wins over every other event, including mid-lockout and mid-pulse.
- Simultaneous `q_Opening` and `q_Bad` (illegal from the lock): Opening wins.

## Configuration
- `NUMLOCK_SUP_STATS_EN` defined: `open_cnt` counter implemented as above.
- Not defined: `open_cnt` is tied to 0 and no counter logic is synthesized. All other behaviour is unchanged.

## Test plan
- Correct code 1-0-1-1 via `U_in`/`Z_in` against the lock model. Required: `U`/`Z` mirror the inputs 1 cycle late; OPEN entered; `open_cnt`=1; `fail_cnt`=0; buttons masked until `q_I`.
- Three bad attempts (U pressed twice from G1), `MAX_FAILS`=3. Required: `fail_cnt` 1, 2, 3; `locked_out`=1 after the third; `U`=`Z`=0 for 64 cycles; exit with `fail_cnt`=0.
- Hold `U_in`=1 through lockout expiry. Required: LOCKOUT persists until release, then IDLE the next cycle.
- Press U once, then idle 32 cycles. Required: `sm_reset` single pulse at idle cycle 32; state IDLE; no pulse while in IDLE.
- Two bad attempts then correct code. Required: `fail_cnt` 2 → 0; no lockout. Pulse `reset` mid-lockout: all outputs return to reset values next edge.
- Build without `NUMLOCK_SUP_STATS_EN`, repeat the open scenario. Required: `open_cnt` stays 0.
